// File: rtl/ucode_sequencer_if.sv
// Host/datapath bundle for the microcode sequencer.
// Host drives program load and control; sequencer returns control word and status.
interface ucode_sequencer_if #(
    parameter int P_PC_W = 5,
    parameter int P_CW   = 15
);
    logic              start;
    logic              abort;
    logic              prog_we;
    logic [P_PC_W-1:0] prog_addr;
    logic [P_CW+1:0]   prog_data;
    logic              mayor;
    logic              bandera;
    logic [P_CW-1:0]   o_signal;
    logic              busy;
    logic              done;
    logic              err;
    logic [P_PC_W-1:0] pc_dbg;

    modport master (
        output start, abort, prog_we, prog_addr, prog_data,
        output mayor, bandera,
        input  o_signal, busy, done, err, pc_dbg
    );

    modport slave (
        input  start, abort, prog_we, prog_addr, prog_data,
        input  mayor, bandera,
        output o_signal, busy, done, err, pc_dbg
    );
endinterface

// File: rtl/ucode_sequencer.sv
// Programmable microcode sequencer: one instruction per cycle from a
// host-loaded program, flag-based branches, HALT/watchdog/abort termination.
module ucode_sequencer #(
    parameter int P_PC_W       = 5,
    parameter int P_CW         = 15,
    parameter int P_MAX_CYCLES = 1000
) (
    input logic              clk,
    input logic              rst,
    ucode_sequencer_if.slave bus
);
    localparam int DEPTH = 1 << P_PC_W;
    localparam int IW    = P_CW + 2;
    localparam int CYC_W = (P_MAX_CYCLES > 1) ? $clog2(P_MAX_CYCLES) : 1;

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {
        OP_EXEC = 2'b00,
        OP_BRM  = 2'b01,
        OP_BRP  = 2'b10,
        OP_HALT = 2'b11
    } op_t;

    logic [IW-1:0]     mem [DEPTH];
    state_t            state;
    logic [P_PC_W-1:0] pc;
    logic              flag_m;
    logic              flag_p;
    logic [CYC_W-1:0]  cyc;
    logic              done_q;
    logic              err_q;

    logic [IW-1:0]     instr;
    op_t               op;
    logic [P_CW-1:0]   field;
    logic [P_PC_W-1:0] pc_inc;
    logic [P_PC_W-1:0] target;
    logic              timeout;
    logic [P_CW-1:0]   o_sig;

    assign instr   = mem[pc];
    assign op      = op_t'(instr[IW-1:P_CW]);
    assign field   = instr[P_CW-1:0];
    assign pc_inc  = pc + 1'b1;
    assign target  = field[P_PC_W-1:0];
    assign timeout = (cyc == CYC_W'(P_MAX_CYCLES - 1));

    assign bus.o_signal = o_sig;
    assign bus.busy     = (state == RUN);
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.pc_dbg   = pc;

    // Program store: host writes only while idle, contents survive reset
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.prog_we)
            mem[bus.prog_addr] <= bus.prog_data;
    end

    // Control word: only EXEC drives the datapath, and never while aborting
    always_comb begin
        o_sig = '0;
        if (state == RUN && !bus.abort && op == OP_EXEC)
            o_sig = field;
    end

    // Sequencer FSM: start, per-instruction pc/flag update, termination
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            pc     <= '0;
            flag_m <= 1'b0;
            flag_p <= 1'b0;
            cyc    <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state <= RUN;
                        pc    <= '0;
                        cyc   <= '0;
                        err_q <= 1'b0;
                    end
                end
                RUN: begin
                    cyc <= cyc + 1'b1;
                    if (bus.abort) begin
                        state <= IDLE;
                    end else if (op == OP_HALT) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end else if (timeout) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                    end else begin
                        unique case (op)
                            OP_EXEC: begin
                                flag_m <= bus.mayor;
                                flag_p <= bus.bandera;
                                pc     <= pc_inc;
                            end
                            OP_BRM:  pc <= flag_m ? target : pc_inc;
                            OP_BRP:  pc <= flag_p ? target : pc_inc;
                            OP_HALT: pc <= pc;
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ucode_sequencer.sv
// Scoreboard bench for ucode_sequencer: stimulus queues expected outputs,
// a negedge monitor pops and compares whenever busy or done is seen.
module tb_ucode_sequencer;
    localparam int PW = 5;
    localparam int CW = 15;

    localparam logic [1:0] EXEC = 2'b00;
    localparam logic [1:0] BRM  = 2'b01;
    localparam logic [1:0] BRP  = 2'b10;
    localparam logic [1:0] HALT = 2'b11;

    typedef struct {
        bit              is_done;
        logic [CW-1:0]   sig;
        logic [PW-1:0]   pc;
        bit              err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t mon_e;

    ucode_sequencer_if #(.P_PC_W(PW), .P_CW(CW)) bus ();

    ucode_sequencer #(
        .P_PC_W(PW),
        .P_CW(CW),
        .P_MAX_CYCLES(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name,
                                  input logic [31:0] act,
                                  input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic logic [CW+1:0] ins(input logic [1:0] op,
                                          input logic [CW-1:0] f);
        return {op, f};
    endfunction

    function automatic void exp_run(input logic [CW-1:0] s,
                                    input logic [PW-1:0] p);
        sb.push_back('{is_done: 1'b0, sig: s, pc: p, err: 1'b0});
    endfunction

    function automatic void exp_done(input bit e);
        sb.push_back('{is_done: 1'b1, sig: '0, pc: '0, err: e});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic [CW+1:0] d);
        bus.prog_we   = 1'b1;
        bus.prog_addr = PW'(a);
        bus.prog_data = d;
        tick();
        bus.prog_we   = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 40) begin
            tick();
            n++;
        end
        check("run_ends", {31'b0, bus.busy}, 32'd0);
        tick();
        tick();
    endtask

    // Monitor: every busy or done cycle must match the next queued entry
    always @(negedge clk) begin
        if (rst && (bus.busy || bus.done)) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output busy=%0b done=%0b pc=%0d required=none",
                         bus.busy, bus.done, bus.pc_dbg);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.is_done) begin
                    check("done", {31'b0, bus.done}, 32'd1);
                    check("err", {31'b0, bus.err}, {31'b0, mon_e.err});
                end else begin
                    check("busy", {31'b0, bus.busy}, 32'd1);
                    check("o_signal", {17'b0, bus.o_signal}, {17'b0, mon_e.sig});
                    check("pc_dbg", {27'b0, bus.pc_dbg}, {27'b0, mon_e.pc});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        bus.mayor     = 1'b0;
        bus.bandera   = 1'b0;
        #2;
        check("rst_o_signal", {17'b0, bus.o_signal}, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_err", {31'b0, bus.err}, 32'd0);
        check("rst_pc", {27'b0, bus.pc_dbg}, 32'd0);
        #10 rst = 1'b1;
        tick();

        // Straight-line program ending in HALT
        load(0, ins(EXEC, 15'h2003));
        load(1, ins(EXEC, 15'h4005));
        load(2, ins(HALT, 15'h0));
        exp_run(15'h2003, 0);
        exp_run(15'h4005, 1);
        exp_run(15'h0, 2);
        exp_done(1'b0);
        do_start();
        wait_idle();

        // BRM taken: flag latched on EXEC, mayor dropped before the branch
        load(0, ins(EXEC, 15'h1234));
        load(1, ins(BRM, 15'd5));
        load(5, ins(HALT, 15'h0));
        bus.mayor = 1'b1;
        exp_run(15'h1234, 0);
        exp_run(15'h0, 1);
        exp_run(15'h0, 5);
        exp_done(1'b0);
        do_start();
        tick();
        bus.mayor = 1'b0;
        wait_idle();

        // BRM not taken
        exp_run(15'h1234, 0);
        exp_run(15'h0, 1);
        exp_run(15'h0, 2);
        exp_done(1'b0);
        do_start();
        wait_idle();

        // BRP taken on bandera
        load(1, ins(BRP, 15'd5));
        bus.bandera = 1'b1;
        exp_run(15'h1234, 0);
        exp_run(15'h0, 1);
        exp_run(15'h0, 5);
        exp_done(1'b0);
        do_start();
        tick();
        bus.bandera = 1'b0;
        wait_idle();

        // BRP ignores mayor
        bus.mayor = 1'b1;
        exp_run(15'h1234, 0);
        exp_run(15'h0, 1);
        exp_run(15'h0, 2);
        exp_done(1'b0);
        do_start();
        wait_idle();
        bus.mayor = 1'b0;

        // HALT on the last allowed cycle beats the watchdog
        for (int i = 0; i < 9; i++) load(i, ins(EXEC, 15'(16'h0100 + i)));
        load(9, ins(HALT, 15'h0));
        for (int i = 0; i < 9; i++) exp_run(15'(16'h0100 + i), PW'(i));
        exp_run(15'h0, 9);
        exp_done(1'b0);
        do_start();
        wait_idle();

        // Endless loop trips the watchdog after 10 RUN cycles
        load(0, ins(EXEC, 15'h0001));
        load(1, ins(BRM, 15'd0));
        bus.mayor = 1'b1;
        for (int i = 0; i < 10; i++)
            exp_run((i % 2 == 0) ? 15'h0001 : 15'h0, PW'(i % 2));
        exp_done(1'b1);
        do_start();
        wait_idle();
        check("err_sticky", {31'b0, bus.err}, 32'd1);
        bus.mayor = 1'b0;

        // Abort on 2nd RUN cycle; write attempted during RUN
        load(0, ins(EXEC, 15'h0011));
        load(1, ins(EXEC, 15'h0022));
        load(2, ins(HALT, 15'h0));
        exp_run(15'h0011, 0);
        exp_run(15'h0, 1);
        do_start();
        check("err_cleared", {31'b0, bus.err}, 32'd0);
        bus.prog_we   = 1'b1;
        bus.prog_addr = 5'd1;
        bus.prog_data = ins(EXEC, 15'h7777);
        tick();
        bus.prog_we = 1'b0;
        bus.abort   = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_idle", {31'b0, bus.busy}, 32'd0);
        tick();
        tick();

        // Read back: memory must be unchanged by the RUN-time write
        exp_run(15'h0011, 0);
        exp_run(15'h0022, 1);
        exp_run(15'h0, 2);
        exp_done(1'b0);
        do_start();
        wait_idle();

        // Asynchronous reset in the middle of a run
        exp_run(15'h0011, 0);
        do_start();
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst_o_signal", {17'b0, bus.o_signal}, 32'd0);
        check("arst_busy", {31'b0, bus.busy}, 32'd0);
        check("arst_pc", {27'b0, bus.pc_dbg}, 32'd0);
        #1 rst = 1'b1;
        tick();

        // pc wraps from 31 to 0
        load(0, ins(EXEC, 15'h0100));
        load(1, ins(BRM, 15'd31));
        load(2, ins(HALT, 15'h0));
        load(31, ins(EXEC, 15'h0F0F));
        bus.mayor = 1'b1;
        exp_run(15'h0100, 0);
        exp_run(15'h0, 1);
        exp_run(15'h0F0F, 31);
        exp_run(15'h0100, 0);
        exp_run(15'h0, 1);
        exp_run(15'h0, 2);
        exp_done(1'b0);
        do_start();
        tick();
        bus.mayor = 1'b0;
        wait_idle();

        // start together with abort in IDLE is refused
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("start_abort_idle", {31'b0, bus.busy}, 32'd0);
        tick();
        tick();

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
